fetch_unit: RTL and testbench

- Consumer side of the program-counter interface. Takes a redirect (taken branch + target) from execute and issues byte reads to instruction memory at a sequential fetch pointer.
- Returns bytes are buffered in a small prefetch FIFO and delivered to decode on a valid/ready stream, each tagged with its source address.
- Sits between the memory port and the decoder. Owns the architectural fetch address, so no separate pc_t instance is needed on this path.

---
 rtl/fetch_unit_if.sv | 45 ++++
 rtl/fetch_unit.sv | 217 +++++++++++++++++++++
 tb/tb_fetch_unit.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: redirect, memory read port and decoder stream of the fetch unit.
// master = fetch unit side; slave = execute/memory/decoder side.
interface fetch_unit_if #(
  parameter int MEM_ADDR_SIZE = 16
);
  logic                     taken_branch_i;
  logic [MEM_ADDR_SIZE-1:0] new_pc_i;
  logic                     mem_req_o;
  logic [MEM_ADDR_SIZE-1:0] mem_addr_o;
  logic                     mem_gnt_i;
  logic                     mem_rvalid_i;
  logic [7:0]               mem_rdata_i;
  logic                     instr_valid_o;
  logic [7:0]               instr_byte_o;
  logic [MEM_ADDR_SIZE-1:0] instr_addr_o;
  logic                     instr_ready_i;

  modport master (
    input  taken_branch_i,
    input  new_pc_i,
    output mem_req_o,
    output mem_addr_o,
    input  mem_gnt_i,
    input  mem_rvalid_i,
    input  mem_rdata_i,
    output instr_valid_o,
    output instr_byte_o,
    output instr_addr_o,
    input  instr_ready_i
  );

  modport slave (
    output taken_branch_i,
    output new_pc_i,
    input  mem_req_o,
    input  mem_addr_o,
    output mem_gnt_i,
    output mem_rvalid_i,
    output mem_rdata_i,
    input  instr_valid_o,
    input  instr_byte_o,
    input  instr_addr_o,
    output instr_ready_i
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: byte fetcher; sequential reads, redirect drain, tagged prefetch FIFO.
// Ports: clk_i, rst_i (sync, active high), bus (fetch_unit_if.master).
// Optional: FETCH_PERF_CNT_EN adds perf_fetched_o, perf_flushes_o, perf_stall_o.
module fetch_unit #(
  parameter int MEM_ADDR_SIZE   = 16,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 3,
  parameter logic [MEM_ADDR_SIZE-1:0] RESET_PC = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]  perf_fetched_o,
  output logic [15:0]  perf_flushes_o,
  output logic [15:0]  perf_stall_o
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = (MAX_OUTSTANDING > 1) ?
                      $clog2(MAX_OUTSTANDING) : 1;

  typedef logic [MEM_ADDR_SIZE-1:0] addr_t;

  typedef struct packed {
    addr_t      addr;
    logic [7:0] data;
  } fetch_ent_t;

  typedef enum logic {
    RUN,
    DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic          run_en_q;
  addr_t         ptr_q, ptr_d;
  logic [OW-1:0] out_q, out_d;
  logic [OW-1:0] disc_q, disc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] rd_q, wr_q;
  fetch_ent_t    fifo_q [FIFO_DEPTH];
  addr_t         tag_q [MAX_OUTSTANDING];
  logic [TW-1:0] tag_wr_q, tag_rd_q;

  logic redirect;
  logic credit;
  logic req;
  logic grant;
  logic rsp;
  logic push;
  logic pop;
  logic valid;

  function automatic logic [TW-1:0] tag_nxt(
    input logic [TW-1:0] p
  );
    return (p == TW'(MAX_OUTSTANDING - 1)) ?
           '0 : p + TW'(1);
  endfunction

  assign redirect = bus.taken_branch_i;

  // Room must exist for every read in flight
  // plus everything already buffered.
  assign credit =
    ((int'(cnt_q) + int'(out_q)) < FIFO_DEPTH) &&
    (int'(out_q) < MAX_OUTSTANDING);

  // run_en_q keeps the port quiet during and
  // for the first cycle after reset.
  assign req   = run_en_q && (state_q == RUN) &&
                 credit && !redirect;
  assign grant = req && bus.mem_gnt_i;

  // With nothing in flight a response is stale
  // (pre-reset) and is ignored.
  assign rsp   = bus.mem_rvalid_i && (out_q != '0);
  assign push  = rsp && (disc_q == '0) && !redirect;
  assign valid = (cnt_q != '0) && !redirect;
  assign pop   = valid && bus.instr_ready_i;

  assign bus.mem_req_o     = req;
  assign bus.mem_addr_o    = ptr_q;
  assign bus.instr_valid_o = valid;
  assign bus.instr_byte_o  = fifo_q[rd_q].data;
  assign bus.instr_addr_o  = fifo_q[rd_q].addr;

  always_comb begin
    out_d   = out_q;
    disc_d  = disc_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    state_d = state_q;

    if (grant && !rsp)
      out_d = out_q + OW'(1);
    else if (!grant && rsp)
      out_d = out_q - OW'(1);

    if (rsp && (disc_q != '0))
      disc_d = disc_q - OW'(1);

    if (push && !pop)
      cnt_d = cnt_q + CW'(1);
    else if (!push && pop)
      cnt_d = cnt_q - CW'(1);

    if (grant)
      ptr_d = ptr_q + addr_t'(1);

    unique case (state_q)
      RUN:   state_d = RUN;
      DRAIN: state_d = (disc_d == '0) ? RUN : DRAIN;
      default: state_d = RUN;
    endcase

    // Every read still in flight belongs to the
    // old stream and must be thrown away.
    if (redirect) begin
      ptr_d   = bus.new_pc_i;
      cnt_d   = '0;
      disc_d  = out_d;
      state_d = (out_d != '0) ? DRAIN : RUN;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= RUN;
      run_en_q <= 1'b0;
      ptr_q    <= RESET_PC;
      out_q    <= '0;
      disc_q   <= '0;
      cnt_q    <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        fifo_q[i] <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++)
        tag_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      run_en_q <= 1'b1;
      ptr_q    <= ptr_d;
      out_q    <= out_d;
      disc_q   <= disc_d;
      cnt_q    <= cnt_d;

      if (redirect) begin
        rd_q <= '0;
        wr_q <= '0;
      end else begin
        if (push)
          wr_q <= wr_q + PW'(1);
        if (pop)
          rd_q <= rd_q + PW'(1);
      end

      if (push)
        fifo_q[wr_q] <= '{addr: tag_q[tag_rd_q],
                          data: bus.mem_rdata_i};

      // Tags retire on every response, dropped
      // or not, to stay aligned with memory.
      if (grant) begin
        tag_q[tag_wr_q] <= ptr_q;
        tag_wr_q        <= tag_nxt(tag_wr_q);
      end
      if (rsp)
        tag_rd_q <= tag_nxt(tag_rd_q);
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetched_q, flushes_q, stall_q;
  logic        stall;

  assign stall = (state_q == RUN) && !credit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetched_q <= '0;
      flushes_q <= '0;
      stall_q   <= '0;
    end else begin
      if (push && (fetched_q != 16'hFFFF))
        fetched_q <= fetched_q + 16'd1;
      if (redirect && (flushes_q != 16'hFFFF))
        flushes_q <= flushes_q + 16'd1;
      if (stall && (stall_q != 16'hFFFF))
        stall_q <= stall_q + 16'd1;
    end
  end

  assign perf_fetched_o = fetched_q;
  assign perf_flushes_o = flushes_q;
  assign perf_stall_o   = stall_q;
`endif

  a_no_overflow: assert property (
    @(posedge clk_i) disable iff (rst_i)
    !(push && (cnt_q == CW'(FIFO_DEPTH)))
  );

  a_out_bound: assert property (
    @(posedge clk_i) disable iff (rst_i)
    out_q <= OW'(MAX_OUTSTANDING)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against an in-order memory model.
// Expected stream is tracked from the last redirect target.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] a;
    int          due;
  } rd_t;

  rd_t         q[$];
  int          nvec      = 0;
  int          nerr      = 0;
  int          ecnt      = 0;
  int          last_due  = 0;
  int          lat_min   = 1;
  int          lat_max   = 1;
  bit          rnd_gnt   = 1'b0;
  int          grants    = 0;
  int          delivered = 0;
  int          maxq      = 0;
  logic [15:0] exp_addr  = 16'h0000;
  logic [15:0] first_addr [4];
  int          first_cnt = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mbyte(
    input logic [15:0] a
  );
    return {a[3:0], a[7:4]} ^ a[15:8] ^ 8'h3C;
  endfunction

  // Memory model and stream monitor; inputs
  // change at negedge, sampling 1 before posedge.
  initial begin
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = 8'h00;
    forever begin
      int due;
      @(negedge clk);
      bus.mem_gnt_i = rnd_gnt ?
        1'($urandom_range(0, 1)) : 1'b1;
      if (q.size() > 0 && q[0].due == ecnt) begin
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = mbyte(q[0].a);
      end else begin
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 8'($urandom);
      end
      #4;
      if (rst) begin
        q.delete();
        last_due = ecnt;
      end else begin
        if (bus.mem_rvalid_i)
          void'(q.pop_front());
        if (bus.mem_req_o && bus.mem_gnt_i) begin
          due = ecnt + $urandom_range(lat_min, lat_max);
          if (due <= last_due)
            due = last_due + 1;
          last_due = due;
          q.push_back('{bus.mem_addr_o, due});
          grants++;
        end
        if (q.size() > maxq)
          maxq = q.size();
        if (bus.instr_valid_o && bus.instr_ready_i) begin
          chk("iaddr", bus.instr_addr_o, exp_addr);
          chk("ibyte", bus.instr_byte_o,
              mbyte(exp_addr));
          if (first_cnt < 4) begin
            first_addr[first_cnt] = bus.instr_addr_o;
            first_cnt++;
          end
          exp_addr++;
          delivered++;
        end
      end
      ecnt++;
    end
  end

  task automatic clr_first();
    first_cnt = 0;
    for (int i = 0; i < 4; i++)
      first_addr[i] = 16'hDEAD;
  endtask

  task automatic redirect(input logic [15:0] pc);
    bus.taken_branch_i = 1'b1;
    bus.new_pc_i       = pc;
    exp_addr           = pc;
    clr_first();
    #1;
    chk("redir_valid", bus.instr_valid_o, 0);
    chk("redir_req", bus.mem_req_o, 0);
    @(negedge clk);
    bus.taken_branch_i = 1'b0;
  endtask

  task automatic wait_q3();
    int n = 0;
    while (q.size() != 3 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("wait3", q.size(), 3);
  endtask

  task automatic chk_rst(input string pfx);
    chk({pfx, "_req"},   bus.mem_req_o, 0);
    chk({pfx, "_valid"}, bus.instr_valid_o, 0);
    chk({pfx, "_maddr"}, bus.mem_addr_o, 16'h0000);
    chk({pfx, "_byte"},  bus.instr_byte_o, 8'h00);
    chk({pfx, "_iaddr"}, bus.instr_addr_o, 16'h0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    rst                = 1'b1;
    bus.taken_branch_i = 1'b0;
    bus.new_pc_i       = 16'h0000;
    bus.instr_ready_i  = 1'b1;
    clr_first();

    // Reset values and first request timing
    repeat (3) @(negedge clk);
    #1 chk_rst("rst");
    @(negedge clk);
    rst = 1'b0;
    #1 chk("req_rel", bus.mem_req_o, 0);
    @(negedge clk);
    #1 chk("req_first", bus.mem_req_o, 1);
    chk("addr_first", bus.mem_addr_o, 16'h0000);
    repeat (14) @(negedge clk);
    chk("seq_prog", delivered >= 8, 1);
    chk("seq_first", first_addr[0], 16'h0000);

    // Back-pressure fills exactly FIFO_DEPTH
    bus.instr_ready_i = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("stall_req", bus.mem_req_o, 0);
    chk("stall_valid", bus.instr_valid_o, 1);
    chk("stall_buf", grants - delivered, 4);
    chk("stall_infl", q.size(), 0);
    chk("stall_maddr", bus.mem_addr_o, 16'(grants));
    chk("stall_head", bus.instr_addr_o, exp_addr);
    @(negedge clk);
    bus.instr_ready_i = 1'b1;
    repeat (10) @(negedge clk);

    // Redirect with 3 reads in flight
    lat_min = 3;
    lat_max = 3;
    wait_q3();
    redirect(16'hC000);
    #1 chk("drain_req", bus.mem_req_o, 0);
    repeat (15) @(negedge clk);
    chk("c000_first", first_addr[0], 16'hC000);
    chk("c000_next", first_addr[1], 16'hC001);

    // Second redirect while draining
    wait_q3();
    redirect(16'hC000);
    #1 chk("drain_req2", bus.mem_req_o, 0);
    redirect(16'h8000);
    repeat (15) @(negedge clk);
    chk("8000_first", first_addr[0], 16'h8000);

    // Address wrap
    lat_min = 1;
    lat_max = 1;
    @(negedge clk);
    redirect(16'hFFFE);
    repeat (12) @(negedge clk);
    chk("wrap0", first_addr[0], 16'hFFFE);
    chk("wrap1", first_addr[1], 16'hFFFF);
    chk("wrap2", first_addr[2], 16'h0000);
    chk("wrap3", first_addr[3], 16'h0001);

    // Random grant, latency and ready
    rnd_gnt = 1'b1;
    lat_min = 1;
    lat_max = 4;
    maxq    = 0;
    redirect(16'h4321);
    d0 = delivered;
    for (int i = 0; i < 240; i++) begin
      bus.instr_ready_i = ($urandom_range(0, 3) != 0);
      if (i == 120)
        redirect(16'h0FF0);
      else
        @(negedge clk);
    end
    bus.instr_ready_i = 1'b1;
    repeat (20) @(negedge clk);
    chk("rnd_maxq", maxq <= 3, 1);
    chk("rnd_prog", delivered > d0 + 20, 1);
    chk("rnd_first", first_addr[0], 16'h0FF0);

    // Reset in the middle of traffic
    rnd_gnt = 1'b0;
    lat_min = 3;
    lat_max = 3;
    wait_q3();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 chk_rst("rst2");
    rst      = 1'b0;
    exp_addr = 16'h0000;
    clr_first();
    repeat (15) @(negedge clk);
    chk("rst2_first", first_addr[0], 16'h0000);
    chk("rst2_next", first_addr[1], 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
